tlb_test_register: RTL

TLB_TEST_REGISTER -- requirements
Module: tlb_test_register

---
 rtl/tlb_test_pkg.sv | 23 ++
 rtl/tlb_test_sequencer.sv | 89 ++++++++
 rtl/tlb_test_register.sv | 108 ++++++++++
 3 files changed

// File: rtl/tlb_test_pkg.sv
// Shared definitions for the TLB test register block: sequencer states,
// TR(CMD)/TR(DATA) field positions and parameter defaults.
package tlb_test_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } seq_state_e;

    // Field positions inside the command/data test registers
    localparam int unsigned TR_C_BIT   = 0;
    localparam int unsigned TR_REP_LO  = 2;
    localparam int unsigned TR_REP_HI  = 3;
    localparam int unsigned TR_HT_BIT  = 4;
    localparam int unsigned TR_TAG_LO  = 12;  // tag runs up to the register MSB

    localparam int unsigned DEF_NUM_REGS   = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_CMD_INDEX  = 6;
    localparam int unsigned DEF_DATA_INDEX = 7;
    localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/tlb_test_sequencer.sv
// Request/acknowledge sequencer for TLB test operations: holds the
// request snapshot, runs the ack timeout and flags lookup completion.
module tlb_test_sequencer
    import tlb_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  start_op,
    input  logic [DATA_WIDTH-1:0] start_cmd,
    input  logic [DATA_WIDTH-1:0] start_data,
    input  logic                  tlb_ack,
    output logic                  busy,
    output logic                  tlb_req,
    output logic                  tlb_op,
    output logic [DATA_WIDTH-1:0] tlb_cmd,
    output logic [DATA_WIDTH-1:0] tlb_data,
    output logic                  timeout_error,
    output logic                  lookup_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    seq_state_e            state, state_next;
    logic [CW-1:0]         count, count_next;
    logic                  op_next, terr_next;
    logic [DATA_WIDTH-1:0] cmd_next, data_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            tlb_op        <= 1'b0;
            tlb_cmd       <= '0;
            tlb_data      <= '0;
            timeout_error <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            tlb_op        <= op_next;
            tlb_cmd       <= cmd_next;
            tlb_data      <= data_next;
            timeout_error <= terr_next;
        end
    end

    // An ack in the final counted cycle still completes the operation.
    always_comb begin
        state_next  = state;
        count_next  = count;
        op_next     = tlb_op;
        cmd_next    = tlb_cmd;
        data_next   = tlb_data;
        terr_next   = timeout_error;
        lookup_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                    count_next = CW'(TIMEOUT);
                    op_next    = start_op;
                    cmd_next   = start_cmd;
                    data_next  = start_data;
                    terr_next  = 1'b0;
                end
            end
            ST_REQ: begin
                if (tlb_ack) begin
                    state_next  = ST_IDLE;
                    lookup_done = tlb_op;
                end else begin
                    count_next = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_next = ST_IDLE;
                        terr_next  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state == ST_REQ);
    assign tlb_req = (state == ST_REQ);

endmodule

// File: rtl/tlb_test_register.sv
// Bank of byte-writable test registers with a registered read port; a
// write to the command register launches a TLB test operation.
module tlb_test_register
    import tlb_test_pkg::*;
#(
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CMD_INDEX  = DEF_CMD_INDEX,
    parameter int unsigned DATA_INDEX = DEF_DATA_INDEX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [$clog2(NUM_REGS)-1:0]    write_index,
    input  logic [DATA_WIDTH/8-1:0]        write_byte_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [$clog2(NUM_REGS)-1:0]    read_index,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] tr_flat,
    output logic                           busy,
    output logic                           timeout_error,
    output logic                           tlb_req,
    output logic                           tlb_op,
    output logic [DATA_WIDTH-1:0]          tlb_cmd,
    output logic [DATA_WIDTH-1:0]          tlb_data,
    input  logic                           tlb_ack,
    input  logic                           tlb_hit,
    input  logic [1:0]                     tlb_rep,
    input  logic [DATA_WIDTH-1:0]          tlb_rdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] TAG_MASK =
        {{(DATA_WIDTH - TR_TAG_LO){1'b1}}, {TR_TAG_LO{1'b0}}};

    logic [DATA_WIDTH-1:0] tr [NUM_REGS];
    logic [DATA_WIDTH-1:0] merged, lookup_value;
    logic wr_in_range, rd_in_range, wr_locked, wr_accept, start, lookup_done;

    always_comb begin
        wr_in_range = 32'(write_index) < NUM_REGS;
        rd_in_range = 32'(read_index) < NUM_REGS;
        wr_locked   = busy && (32'(write_index) == CMD_INDEX ||
                               32'(write_index) == DATA_INDEX);
        wr_accept   = write_enable && wr_in_range && !wr_locked;
        start       = wr_accept && 32'(write_index) == CMD_INDEX &&
                      write_byte_enable[0];
    end

    always_comb begin
        merged = wr_in_range ? tr[write_index] : '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (write_byte_enable[b])
                merged[b*8 +: 8] = write_data[b*8 +: 8];
        end
    end

    // Lookup result: hit/rep always land, the tag only on a hit.
    always_comb begin
        lookup_value                         = tr[DATA_INDEX];
        lookup_value[TR_HT_BIT]              = tlb_hit;
        lookup_value[TR_REP_HI:TR_REP_LO]    = tlb_rep;
        if (tlb_hit)
            lookup_value = (lookup_value & ~TAG_MASK) | (tlb_rdata & TAG_MASK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                tr[i] <= '0;
            read_data <= '0;
        end else begin
            if (wr_accept)
                tr[write_index] <= merged;
            if (lookup_done)
                tr[DATA_INDEX] <= lookup_value;
            read_data <= rd_in_range ? tr[read_index] : '0;
        end
    end

    always_comb begin
        tr_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            tr_flat[i*DATA_WIDTH +: DATA_WIDTH] = tr[i];
    end

    tlb_test_sequencer #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_sequencer (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_op      (write_data[TR_C_BIT]),
        .start_cmd     (merged),
        .start_data    (tr[DATA_INDEX]),
        .tlb_ack       (tlb_ack),
        .busy          (busy),
        .tlb_req       (tlb_req),
        .tlb_op        (tlb_op),
        .tlb_cmd       (tlb_cmd),
        .tlb_data      (tlb_data),
        .timeout_error (timeout_error),
        .lookup_done   (lookup_done)
    );

endmodule
